// File: rtl/simon_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : simon_key_debounce
//  Purpose  : Synchronises and debounces the Simon colour keys and start
//             button into clean single-cycle one-hot key and start pulses.
//  Revision : 1.0  initial release
// ============================================================================
module simon_key_debounce #(
    parameter int unsigned DEB_CYCLES = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] raw_k,
    input  logic       raw_start,
    output logic [3:0] k,
    output logic [1:0] key_code,
    output logic       key_valid,
    output logic       start,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEB  = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [3:0]       k_s1_q, k_s2_q;
    logic             st_s1_q, st_s2_q;

    state_t           key_state_q, key_state_d;
    logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
    logic [3:0]       key_lat_q, key_lat_d;
    logic             key_acc_d;

    state_t           st_state_q, st_state_d;
    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
    logic             st_acc_d;

    logic [3:0]       key_first_d;
    logic [1:0]       key_idx_d;

    logic [3:0]       k_q;
    logic [1:0]       key_code_q;
    logic             key_valid_q;
    logic             start_q;
    logic             busy_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k_s1_q  <= '0;
            k_s2_q  <= '0;
            st_s1_q <= 1'b0;
            st_s2_q <= 1'b0;
        end else begin
            k_s1_q  <= raw_k;
            k_s2_q  <= k_s1_q;
            st_s1_q <= raw_start;
            st_s2_q <= st_s1_q;
        end
    end

    always_comb begin
        key_state_d = key_state_q;
        key_cnt_d   = key_cnt_q;
        key_lat_d   = key_lat_q;
        key_acc_d   = 1'b0;
        case (key_state_q)
            IDLE: begin
                if (k_s2_q != 4'b0000) begin
                    key_lat_d   = k_s2_q;
                    key_cnt_d   = '0;
                    key_state_d = DEB;
                end
            end
            DEB: begin
                if (k_s2_q == key_lat_q) begin
                    if (key_cnt_q == C_CNT_MAX) begin
                        key_acc_d   = 1'b1;
                        key_state_d = HELD;
                    end else begin
                        key_cnt_d = key_cnt_q + C_CNT_ONE;
                    end
                end else if (k_s2_q == 4'b0000) begin
                    key_state_d = IDLE;
                end else begin
                    // A different key combination restarts the stability window
                    key_lat_d = k_s2_q;
                    key_cnt_d = '0;
                end
            end
            HELD: begin
                if (k_s2_q == 4'b0000) begin
                    key_cnt_d   = '0;
                    key_state_d = REL;
                end
            end
            REL: begin
                if (k_s2_q != 4'b0000) begin
                    key_state_d = HELD;
                end else if (key_cnt_q == C_CNT_MAX) begin
                    key_state_d = IDLE;
                end else begin
                    key_cnt_d = key_cnt_q + C_CNT_ONE;
                end
            end
            default: key_state_d = IDLE;
        endcase
    end

    // Single-bit input: the latched vector is always 1 in DEB, so it is implied
    always_comb begin
        st_state_d = st_state_q;
        st_cnt_d   = st_cnt_q;
        st_acc_d   = 1'b0;
        case (st_state_q)
            IDLE: begin
                if (st_s2_q) begin
                    st_cnt_d   = '0;
                    st_state_d = DEB;
                end
            end
            DEB: begin
                if (!st_s2_q) begin
                    st_state_d = IDLE;
                end else if (st_cnt_q == C_CNT_MAX) begin
                    st_acc_d   = 1'b1;
                    st_state_d = HELD;
                end else begin
                    st_cnt_d = st_cnt_q + C_CNT_ONE;
                end
            end
            HELD: begin
                if (!st_s2_q) begin
                    st_cnt_d   = '0;
                    st_state_d = REL;
                end
            end
            REL: begin
                if (st_s2_q) begin
                    st_state_d = HELD;
                end else if (st_cnt_q == C_CNT_MAX) begin
                    st_state_d = IDLE;
                end else begin
                    st_cnt_d = st_cnt_q + C_CNT_ONE;
                end
            end
            default: st_state_d = IDLE;
        endcase
    end

    // Red wins over green over yellow over blue, matching the controller
    always_comb begin
        key_first_d = 4'b0000;
        key_idx_d   = 2'd0;
        if (key_lat_q[0]) begin
            key_first_d = 4'b0001;
            key_idx_d   = 2'd0;
        end else if (key_lat_q[1]) begin
            key_first_d = 4'b0010;
            key_idx_d   = 2'd1;
        end else if (key_lat_q[2]) begin
            key_first_d = 4'b0100;
            key_idx_d   = 2'd2;
        end else if (key_lat_q[3]) begin
            key_first_d = 4'b1000;
            key_idx_d   = 2'd3;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_state_q <= IDLE;
            key_cnt_q   <= '0;
            key_lat_q   <= '0;
            st_state_q  <= IDLE;
            st_cnt_q    <= '0;
            k_q         <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            key_state_q <= key_state_d;
            key_cnt_q   <= key_cnt_d;
            key_lat_q   <= key_lat_d;
            st_state_q  <= st_state_d;
            st_cnt_q    <= st_cnt_d;
            k_q         <= key_acc_d ? key_first_d : 4'b0000;
            key_code_q  <= key_acc_d ? key_idx_d : 2'd0;
            key_valid_q <= key_acc_d;
            start_q     <= st_acc_d;
            busy_q      <= (key_state_d != IDLE);
        end
    end

    assign k         = k_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign start     = start_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/simon_key_debounce.md
Name: simon_key_debounce

Overview:
- Input conditioning stage that sits directly upstream of the Simon-game controller.
- Takes the raw, asynchronous, bouncing colour keys and start button and synchronises and debounces them.
- Emits clean single-cycle one-hot key pulses on k[3:0] and a single-cycle start pulse, both directly consumable by the controller's k/start inputs.
- Guarantees at most one key pulse per physical press and never more than one k bit high at a time.

Parameters:
- DEB_CYCLES, 8: consecutive stable synchronised samples required to accept a press or a release. Legal range 2..15.
- CNT_W, 4: debounce counter width. Must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clock  input  1  single system clock; all flops rise-edge.
- reset  input  1  asynchronous, active-high reset.
- raw_k  input  4  raw colour keys (bit0 red, bit1 green, bit2 yellow, bit3 blue); active high; asynchronous.
- raw_start  input  1  raw start button; active high; asynchronous.
- k  output  4  one-hot key press pulse, registered.
- key_code  output  2  index of the pulsed key; valid while key_valid=1.
- key_valid  output  1  high exactly when k != 0.
- start  output  1  single-cycle start pulse, registered.
- busy  output  1  key FSM not in IDLE, registered.

Behaviour:
- Reset (async, active-high): all synchroniser flops, counters, latched vector and outputs go to 0; key FSM and start FSM go to IDLE.
  - Reset asserted mid-press drops any pending pulse.
  - After reset release, a key already held is treated as a new press.
- Synchroniser: 2-flop chain per input (raw->s1->s2). FSMs see only s2.
- Key FSM states: IDLE, DEB, HELD, REL.
  - IDLE: if s2_k != 0, latch lat = s2_k, cnt = 0, go to DEB.
  - DEB, s2_k == lat: if cnt == DEB_CYCLES-1, assert k = lowest set bit of lat (one-hot), key_code = its index, key_valid = 1 for exactly one cycle, go to HELD; else cnt++.
  - DEB, s2_k != lat and s2_k == 0: go to IDLE, no pulse.
  - DEB, s2_k != lat and s2_k != 0: re-latch lat = s2_k, cnt = 0, stay in DEB.
  - HELD: if s2_k == 0, cnt = 0, go to REL. Additional keys pressed while HELD are ignored; no second pulse.
  - REL: if s2_k != 0, go to HELD. Otherwise, if cnt == DEB_CYCLES-1 go to IDLE, else cnt++.
- Priority: with several keys latched, bit0 > bit1 > bit2 > bit3. This matches the controller's if/else order.
- Latency: raw_k stable from before edge E0 gives k high in the cycle following edge E0+DEB_CYCLES+2. k is low again after the next edge.
- Start FSM: independent copy of the same four-state scheme on s2_start, with its own counter. Emits start = 1 for one cycle on accepted press, same latency.
  - Start and key pulses may coincide; neither blocks the other.
- Counter never wraps: cnt saturates at DEB_CYCLES-1 because a transition always occurs there.
- busy = (key FSM != IDLE). Start FSM state is not reflected in busy.
- No combinational path from any input to any output.

Test Plan:
- Reset, then raw_k = 4'b0010 held clean from edge E0 (DEB_CYCLES=8) -> k = 4'b0010, key_code = 1, key_valid = 1 for exactly one cycle after edge E0+10; k = 0 afterwards while the key stays held.
- raw_k = 4'b0001 bounced 0/1 every 3 cycles for 20 cycles, then stable -> no pulse during bouncing; one pulse k = 4'b0001 exactly DEB_CYCLES+2 edges after the last transition.
- raw_k = 4'b1100 pressed simultaneously -> single pulse k = 4'b0100, key_code = 2. Adding bit0 while HELD -> no further pulse until full release plus DEB_CYCLES zero samples.
- Press red, release for 5 cycles, re-press (DEB_CYCLES=8) -> no second pulse, because release was never accepted. Release for 12 cycles, then press -> second pulse.
- raw_start and raw_k = 4'b1000 asserted on the same cycle -> start and k = 4'b1000 both pulse in the same cycle.
- reset asserted while key FSM is in DEB at cnt = 5 -> outputs 0 immediately, busy = 0. Key still held after reset -> pulse DEB_CYCLES+2 edges after reset deassertion.
